// File: rtl/button_event_pkg.sv
// Shared types and default timing for the button gesture decoder.
package button_event_pkg;

  typedef enum logic [2:0] {
    ARM    = 3'd0,
    IDLE   = 3'd1,
    PRESS1 = 3'd2,
    WAIT2  = 3'd3,
    PRESS2 = 3'd4,
    LONG   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    EV_NONE   = 3'd0,
    EV_CLICK  = 3'd1,
    EV_DOUBLE = 3'd2,
    EV_LONG   = 3'd3,
    EV_REPEAT = 3'd4
  } ev_t;

  localparam int unsigned DEF_LONG_CYCLES   = 25_000_000;
  localparam int unsigned DEF_GAP_CYCLES    = 10_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES = 5_000_000;
  localparam int unsigned DEF_CNT_W         = 25;

  // One-hot pulse vector {click, double_click, long_press, repeat_tick}.
  function automatic logic [3:0] ev_pulses(input ev_t ev);
    case (ev)
      EV_CLICK:  return 4'b1000;
      EV_DOUBLE: return 4'b0100;
      EV_LONG:   return 4'b0010;
      EV_REPEAT: return 4'b0001;
      default:   return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into click / double / long / repeat pulses.
//
// state  | meaning
// ARM    | wait for the button to be seen released after reset
// IDLE   | released, no gesture in progress
// PRESS1 | first press, counting high samples toward a long press
// WAIT2  | short press released, counting the double-click gap
// PRESS2 | second press of a double click, waiting for release
// LONG   | long press held, counting repeat periods
module button_event_decoder
  import button_event_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  output logic click,
  output logic double_click,
  output logic long_press,
  output logic repeat_tick,
  output logic held
);

  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;
  localparam bit PARAMS_OK =
    (CNT_W >= 2) && (CNT_W <= 31) &&
    (LONG_CYCLES >= 2)   && (64'(LONG_CYCLES)   <= CNT_MAX) &&
    (GAP_CYCLES >= 2)    && (64'(GAP_CYCLES)    <= CNT_MAX) &&
    (REPEAT_CYCLES >= 2) && (64'(REPEAT_CYCLES) <= CNT_MAX);

  if (!PARAMS_OK) begin : g_bad_params
    $error("button_event_decoder: *_CYCLES must be in [2, 2^CNT_W-1]");
  end

  // Compare against N-1 so the sample that would make the count N is the deciding one.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARM;
      cnt   <= '0;
      held  <= 1'b0;
      {click, double_click, long_press, repeat_tick} <= 4'b0000;
    end else begin
      {click, double_click, long_press, repeat_tick} <= ev_pulses(EV_NONE);
      held <= 1'b0;
      case (state)
        ARM: begin
          if (!btn_level) state <= IDLE;
        end
        IDLE: begin
          if (btn_level) begin
            state <= PRESS1;
            cnt   <= ONE;
          end
        end
        PRESS1: begin
          if (btn_level) begin
            if (cnt == LONG_LAST) begin
              state <= LONG;
              cnt   <= '0;
              held  <= 1'b1;
              {click, double_click, long_press, repeat_tick} <= ev_pulses(EV_LONG);
            end else begin
              cnt <= cnt + ONE;
            end
          end else begin
            state <= WAIT2;
            cnt   <= ONE;
          end
        end
        WAIT2: begin
          if (btn_level) begin
            state <= PRESS2;
            cnt   <= '0;
            {click, double_click, long_press, repeat_tick} <= ev_pulses(EV_DOUBLE);
          end else if (cnt == GAP_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            {click, double_click, long_press, repeat_tick} <= ev_pulses(EV_CLICK);
          end else begin
            cnt <= cnt + ONE;
          end
        end
        PRESS2: begin
          if (!btn_level) state <= IDLE;
        end
        LONG: begin
          if (btn_level) begin
            held <= 1'b1;
            if (cnt == REPEAT_LAST) begin
              cnt <= '0;
              {click, double_click, long_press, repeat_tick} <= ev_pulses(EV_REPEAT);
            end else begin
              cnt <= cnt + ONE;
            end
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ARM;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
